// File: rtl/alu_ex_stage.sv
// Two-stage execute wrapper around the external 32-bit ALU: S1 holds decoded
// operands driving the ALU, S2 captures result/flags for the MEM stage.
module alu_ex_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [1:0]   in_ctl,
    input  logic [5:0]   in_funct,
    input  logic         flush,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    output logic         alu_c0,
    input  logic [W-1:0] alu_result,
    input  logic         alu_nz,
    input  logic         alu_v,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_zero,
    output logic         out_ovf,
    output logic         out_illegal,
    output logic [7:0]   ovf_count
);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_XOR = 3'b011,
        OP_NOR = 3'b100,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

    alu_op_e dec_op;
    logic    dec_c0;
    logic    dec_illegal;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        dec_op      = OP_ADD;
        dec_illegal = 1'b0;
        unique case (in_ctl)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b11: dec_op = OP_OR;
            2'b10: begin
                case (in_funct)
                    6'h20, 6'h21: dec_op = OP_ADD;
                    6'h22, 6'h23: dec_op = OP_SUB;
                    6'h24:        dec_op = OP_AND;
                    6'h25:        dec_op = OP_OR;
                    6'h26:        dec_op = OP_XOR;
                    6'h27:        dec_op = OP_NOR;
                    6'h2A:        dec_op = OP_SLT;
                    default:      dec_illegal = 1'b1;
                endcase
            end
            default: dec_op = OP_ADD;
        endcase
        dec_c0 = (dec_op == OP_SUB) || (dec_op == OP_SLT);
    end

    logic         s1_valid;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    alu_op_e      s1_op;
    logic         s1_c0;
    logic         s1_illegal;

    logic         s2_valid;
    logic [W-1:0] s2_result;
    logic         s2_zero;
    logic         s2_ovf;
    logic         s2_illegal;

    logic s2_free;
    logic s1_adv;
    logic accept;
    logic consume;

    assign s2_free  = ~s2_valid | out_ready;
    assign s1_adv   = s1_valid & s2_free;
    assign in_ready = ~s1_valid | s2_free;
    assign accept   = in_valid & in_ready;
    assign consume  = s2_valid & out_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_op      <= OP_AND;
            s1_c0      <= 1'b0;
            s1_illegal <= 1'b0;
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_zero    <= 1'b0;
            s2_ovf     <= 1'b0;
            s2_illegal <= 1'b0;
        end else if (flush) begin
            // Kill both stages; data registers keep their contents.
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid   <= 1'b1;
                s1_a       <= in_a;
                s1_b       <= in_b;
                s1_op      <= dec_op;
                s1_c0      <= dec_c0;
                s1_illegal <= dec_illegal;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_adv) begin
                s2_valid   <= 1'b1;
                s2_result  <= alu_result;
                s2_zero    <= ~alu_nz;
                s2_ovf     <= alu_v & ((s1_op == OP_ADD) || (s1_op == OP_SUB));
                s2_illegal <= s1_illegal;
            end else if (consume) begin
                s2_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_count <= 8'd0;
        end else if (!flush && consume && s2_ovf && (ovf_count != 8'hFF)) begin
            ovf_count <= ovf_count + 8'd1;
        end
    end

    assign alu_a       = s1_a;
    assign alu_b       = s1_b;
    assign alu_op      = s1_op;
    assign alu_c0      = s1_c0;
    assign out_valid   = s2_valid;
    assign out_result  = s2_result;
    assign out_zero    = s2_zero;
    assign out_ovf     = s2_ovf;
    assign out_illegal = s2_illegal;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage with a behavioural model of the attached ALU.
module tb_alu_ex_stage;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [1:0]   in_ctl;
    logic [5:0]   in_funct;
    logic         flush;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_op;
    logic         alu_c0;
    logic [W-1:0] alu_result;
    logic         alu_nz;
    logic         alu_v;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_zero;
    logic         out_ovf;
    logic         out_illegal;
    logic [7:0]   ovf_count;

    int n_tests = 0;
    int n_fail  = 0;

    alu_ex_stage #(.W(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ctl(in_ctl), .in_funct(in_funct),
        .flush(flush),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c0(alu_c0),
        .alu_result(alu_result), .alu_nz(alu_nz), .alu_v(alu_v),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_ovf(out_ovf),
        .out_illegal(out_illegal), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    // Attached ALU: shared adder (b inverted when carry-in set), overflow from the adder.
    logic [W-1:0] bb;
    logic [W-1:0] sum;
    always_comb begin
        bb    = alu_c0 ? ~alu_b : alu_b;
        sum   = alu_a + bb + {{(W-1){1'b0}}, alu_c0};
        alu_v = (alu_a[W-1] == bb[W-1]) && (sum[W-1] != alu_a[W-1]);
        case (alu_op)
            3'b000:  alu_result = alu_a & alu_b;
            3'b001:  alu_result = alu_a | alu_b;
            3'b010:  alu_result = sum;
            3'b011:  alu_result = alu_a ^ alu_b;
            3'b100:  alu_result = ~(alu_a | alu_b);
            3'b110:  alu_result = sum;
            3'b111:  alu_result = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            default: alu_result = '0;
        endcase
        alu_nz = |alu_result;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] ctl, input logic [5:0] funct,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_ctl   = ctl;
        in_funct = funct;
        in_a     = a;
        in_b     = b;
    endtask

    // Single op through an empty pipe with out_ready high; result is consumed on the final edge.
    task automatic run_op(input string tag, input logic [1:0] ctl, input logic [5:0] funct,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e_res, input logic e_zero,
                          input logic e_ovf, input logic e_ill);
        drive(ctl, funct, a, b);
        cyc();
        in_valid = 1'b0;
        cyc();
        check({tag, ".valid"}, out_valid, 1);
        check({tag, ".result"}, out_result, e_res);
        check({tag, ".zero"}, out_zero, e_zero);
        check({tag, ".ovf"}, out_ovf, e_ovf);
        check({tag, ".illegal"}, out_illegal, e_ill);
        cyc();
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_ctl    = 2'b00;
        in_funct  = 6'h00;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        cyc();
        cyc();
        check("rst.out_valid", out_valid, 0);
        check("rst.ovf_count", ovf_count, 0);
        check("rst.alu_op", alu_op, 3'b000);
        check("rst.alu_c0", alu_c0, 0);
        check("rst.out_result", out_result, 0);
        check("rst.out_zero", out_zero, 0);
        reset_n = 1'b1;
        cyc();
        check("rst.in_ready", in_ready, 1);

        // SUB 5-5 via funct 0x22: ALU controls visible while in S1
        drive(2'b10, 6'h22, 32'd5, 32'd5);
        cyc();
        in_valid = 1'b0;
        check("sub.s1_op", alu_op, 3'b110);
        check("sub.s1_c0", alu_c0, 1);
        check("sub.s1_notout", out_valid, 0);
        cyc();
        check("sub.valid", out_valid, 1);
        check("sub.result", out_result, 0);
        check("sub.zero", out_zero, 1);
        check("sub.ovf", out_ovf, 0);
        cyc();
        check("sub.drained", out_valid, 0);

        // Signed overflow on ADD, then SLT on the same operands back to back
        drive(2'b00, 6'h00, 32'h7FFF_FFFF, 32'd1);
        cyc();
        drive(2'b10, 6'h2A, 32'h7FFF_FFFF, 32'd1);
        cyc();
        in_valid = 1'b0;
        check("add_ovf.result", out_result, 32'h8000_0000);
        check("add_ovf.ovf", out_ovf, 1);
        check("add_ovf.cnt_before", ovf_count, 0);
        cyc();
        check("add_ovf.cnt_after", ovf_count, 1);
        check("slt.result", out_result, 0);
        check("slt.ovf", out_ovf, 0);
        cyc();
        check("slt.drained", out_valid, 0);

        // SLT whose subtraction overflows still reports no overflow; AND ignores adder overflow
        run_op("slt_neg", 2'b10, 6'h2A, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        run_op("and_gate", 2'b10, 6'h24, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        run_op("illegal", 2'b10, 6'h3F, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1'b1);
        run_op("ori", 2'b11, 6'h00, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
        run_op("addu", 2'b10, 6'h21, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0);
        check("gated.cnt", ovf_count, 1);

        // Four-op stream with a three-cycle downstream stall after the first result
        drive(2'b10, 6'h20, 32'd1, 32'd2);
        cyc();
        drive(2'b10, 6'h26, 32'h0000_00FF, 32'h0000_000F);
        cyc();
        check("strm.r0", out_result, 32'd3);
        check("strm.v0", out_valid, 1);
        out_ready = 1'b0;
        drive(2'b10, 6'h27, 32'd0, 32'd0);
        #1;
        check("strm.in_ready_low", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("strm.hold_valid", out_valid, 1);
            check("strm.hold_result", out_result, 32'd3);
            check("strm.hold_alu_a", alu_a, 32'h0000_00FF);
            check("strm.hold_alu_op", alu_op, 3'b011);
            check("strm.hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        cyc();
        check("strm.r1", out_result, 32'h0000_00F0);
        drive(2'b11, 6'h00, 32'h0000_00F0, 32'h0000_000F);
        cyc();
        in_valid = 1'b0;
        check("strm.r2", out_result, 32'hFFFF_FFFF);
        check("strm.r2_zero", out_zero, 0);
        cyc();
        check("strm.r3", out_result, 32'h0000_00FF);
        check("strm.v3", out_valid, 1);
        cyc();
        check("strm.drained", out_valid, 0);

        // Flush with both stages full and a new op offered: nothing survives, count untouched
        out_ready = 1'b0;
        drive(2'b00, 6'h00, 32'h7FFF_FFFF, 32'd1);
        cyc();
        drive(2'b00, 6'h00, 32'd1, 32'd2);
        cyc();
        check("flush.full_valid", out_valid, 1);
        check("flush.full_in_ready", in_ready, 0);
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(2'b00, 6'h00, 32'd100, 32'd200);
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush.out_valid", out_valid, 0);
        check("flush.in_ready", in_ready, 1);
        check("flush.cnt", ovf_count, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("flush.no_ghost", out_valid, 0);
        end

        // Saturating overflow counter: 10 stream cycles -> 8 consumes
        drive(2'b00, 6'h00, 32'h7FFF_FFFF, 32'd1);
        for (int i = 0; i < 10; i++) cyc();
        check("sat.cnt_mid", ovf_count, 9);
        for (int i = 0; i < 300; i++) cyc();
        check("sat.cnt_full", ovf_count, 255);
        check("sat.valid", out_valid, 1);

        // Asynchronous reset mid-stream, observed before the next edge
        reset_n = 1'b0;
        #1;
        check("arst.cnt", ovf_count, 0);
        check("arst.out_valid", out_valid, 0);
        check("arst.out_result", out_result, 0);
        check("arst.alu_op", alu_op, 3'b000);
        in_valid = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
        check("arst.post_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
